// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and small enums used by the butterfly datapath.
package kyber_pkg;

  localparam int KYBER_DATA_WIDTH = 12;
  localparam int KYBER_Q          = 3329;
  localparam int KYBER_MUL_LAT    = 4;

  typedef enum logic {
    MODE_CT = 1'b0,
    MODE_GS = 1'b1
  } bf_mode_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_HALF = 2'd2
  } mas_op_e;

endpackage

// File: rtl/butterfly_core_if.sv
// Issue, multiplier and result signals of the butterfly core, bundled as one interface.
interface butterfly_core_if #(
  parameter int data_width = kyber_pkg::KYBER_DATA_WIDTH
);

  logic                  in_valid;
  logic                  mode;
  logic                  half_en;
  logic [data_width-1:0] u_in;
  logic [data_width-1:0] v_in;
  logic [data_width-1:0] w_in;
  logic [data_width-1:0] mul_a;
  logic [data_width-1:0] mul_b;
  logic [data_width-1:0] mul_p;
  logic                  out_valid;
  logic [data_width-1:0] x_out;
  logic [data_width-1:0] y_out;

  // The master side is the environment: issuer plus the external multiplier.
  modport master (
    output in_valid, mode, half_en, u_in, v_in, w_in, mul_p,
    input  mul_a, mul_b, out_valid, x_out, y_out
  );

  modport slave (
    input  in_valid, mode, half_en, u_in, v_in, w_in, mul_p,
    output mul_a, mul_b, out_valid, x_out, y_out
  );

endinterface

// File: rtl/butterfly_core_mod_add_sub.sv
// Combinational modular add, subtract or halve with a single conditional correction.
module mod_add_sub
  import kyber_pkg::*;
#(
  parameter int data_width = KYBER_DATA_WIDTH,
  parameter int Q          = KYBER_Q
) (
  input  mas_op_e               op,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  output logic [data_width-1:0] r
);

  localparam logic [data_width:0] QW = (data_width + 1)'(Q);

  logic [data_width:0] sum;
  logic [data_width:0] diff;
  logic [data_width:0] odd_sum;

  // One extra bit holds the carry/borrow; a sum equal to Q folds to 0.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    odd_sum = {1'b0, a} + QW;
    r       = '0;
    unique case (op)
      OP_ADD:  r = (sum >= QW) ? data_width'(sum - QW) : sum[data_width-1:0];
      OP_SUB:  r = diff[data_width] ? data_width'(diff + QW) : diff[data_width-1:0];
      OP_HALF: r = a[0] ? odd_sum[data_width:1] : {1'b0, a[data_width-1:1]};
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/butterfly_core.sv
// Pipelined CT/GS NTT butterfly around an external MUL_LAT-cycle modular multiplier.
module butterfly_core
  import kyber_pkg::*;
#(
  parameter int data_width = KYBER_DATA_WIDTH,
  parameter int Q          = KYBER_Q,
  parameter int MUL_LAT    = KYBER_MUL_LAT
) (
  input logic             clk,
  input logic             rst,
  butterfly_core_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    bf_mode_e              mode;
    logic                  half_en;
    logic [data_width-1:0] t;
  } stage_t;

  stage_t pipe [MUL_LAT];
  stage_t tap;

  logic                  issue_gs;
  logic [data_width-1:0] uv_sum;
  logic [data_width-1:0] uv_diff;
  logic [data_width-1:0] t_in;
  logic [data_width-1:0] tp_sum;
  logic [data_width-1:0] tp_diff;
  logic [data_width-1:0] x_raw;
  logic [data_width-1:0] y_raw;
  logic [data_width-1:0] x_half;
  logic [data_width-1:0] y_half;

  assign issue_gs = (bf_mode_e'(bus.mode) == MODE_GS);

  mod_add_sub #(.data_width(data_width), .Q(Q)) uv_add_i (
    .op(OP_ADD), .a(bus.u_in), .b(bus.v_in), .r(uv_sum)
  );

  mod_add_sub #(.data_width(data_width), .Q(Q)) uv_sub_i (
    .op(OP_SUB), .a(bus.u_in), .b(bus.v_in), .r(uv_diff)
  );

  assign t_in      = issue_gs ? uv_sum : bus.u_in;
  assign bus.mul_a = issue_gs ? uv_diff : bus.v_in;
  assign bus.mul_b = bus.w_in;

  // Side-band shift register, aligned so its last tap meets mul_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= stage_t'{valid:   bus.in_valid,
                          mode:    bf_mode_e'(bus.mode),
                          half_en: bus.half_en,
                          t:       t_in};
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tap = pipe[MUL_LAT-1];

  mod_add_sub #(.data_width(data_width), .Q(Q)) tp_add_i (
    .op(OP_ADD), .a(tap.t), .b(bus.mul_p), .r(tp_sum)
  );

  mod_add_sub #(.data_width(data_width), .Q(Q)) tp_sub_i (
    .op(OP_SUB), .a(tap.t), .b(bus.mul_p), .r(tp_diff)
  );

  assign x_raw = (tap.mode == MODE_GS) ? tap.t     : tp_sum;
  assign y_raw = (tap.mode == MODE_GS) ? bus.mul_p : tp_diff;

  mod_add_sub #(.data_width(data_width), .Q(Q)) x_half_i (
    .op(OP_HALF), .a(x_raw), .b('0), .r(x_half)
  );

  mod_add_sub #(.data_width(data_width), .Q(Q)) y_half_i (
    .op(OP_HALF), .a(y_raw), .b('0), .r(y_half)
  );

  // Results hold their last value while no operation is staged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
    end else if (tap.valid) begin
      bus.out_valid <= 1'b1;
      bus.x_out     <= tap.half_en ? x_half : x_raw;
      bus.y_out     <= tap.half_en ? y_half : y_raw;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_butterfly_core.sv
// Scoreboard bench for butterfly_core with a behavioural pipelined modular multiplier.
module tb_butterfly_core;
  import kyber_pkg::*;

  localparam int DW      = KYBER_DATA_WIDTH;
  localparam int Q       = KYBER_Q;
  localparam int MUL_LAT = KYBER_MUL_LAT;

  typedef struct {
    int x;
    int y;
    int issue_cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   last_x = 0;
  int   last_y = 0;
  exp_t sb[$];
  exp_t got;

  butterfly_core_if #(.data_width(DW)) bus ();

  butterfly_core #(.data_width(DW), .Q(Q), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Multiplier model in Barrett mode (sel tied to 1), sharing the core's reset.
  logic [DW-1:0] mul_pipe [MUL_LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
    end else begin
      mul_pipe[0] <= DW'((32'(bus.mul_a) * 32'(bus.mul_b)) % 32'(Q));
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end
  assign bus.mul_p = mul_pipe[MUL_LAT-1];

  always @(posedge clk) begin
    if (!rst && bus.in_valid)
      assert (bus.u_in < DW'(Q) && bus.v_in < DW'(Q) && bus.w_in < DW'(Q))
        else $error("[TB] non-canonical operand issued");
  end

  task automatic check_output(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic int halve(input int r);
    return (r % 2 == 0) ? r / 2 : (r + Q) / 2;
  endfunction

  function automatic exp_t golden(input bit gs, input bit half, input int u, input int v, input int w);
    exp_t e;
    int p;
    if (!gs) begin
      p   = (v * w) % Q;
      e.x = (u + p) % Q;
      e.y = (u - p + Q) % Q;
    end else begin
      e.x = (u + v) % Q;
      e.y = (((u - v + Q) % Q) * w) % Q;
    end
    if (half) begin
      e.x = halve(e.x);
      e.y = halve(e.y);
    end
    e.issue_cycle = 0;
    return e;
  endfunction

  // Drives one issue cycle; called #1 after a rising edge and returns at the same phase.
  task automatic apply_stimulus(input bit gs, input bit half, input int u, input int v, input int w,
                                input int ex, input int ey, input bit push);
    bus.in_valid = 1'b1;
    bus.mode     = gs;
    bus.half_en  = half;
    bus.u_in     = DW'(u);
    bus.v_in     = DW'(v);
    bus.w_in     = DW'(w);
    if (push) sb.push_back(exp_t'{x: ex, y: ey, issue_cycle: cycle});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_output("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        check_output("unexpected_out_valid", 1, 0);
      end else begin
        got = sb.pop_front();
        check_output("x_out", int'(bus.x_out), got.x);
        check_output("y_out", int'(bus.y_out), got.y);
        check_output("latency", cycle - got.issue_cycle, MUL_LAT + 1);
        last_x = got.x;
        last_y = got.y;
      end
    end
  end

  initial begin
    int quiet;
    exp_t e;
    bit gs, half;
    int u, v, w;

    bus.in_valid = 1'b0;
    bus.mode     = 1'b0;
    bus.half_en  = 1'b0;
    bus.u_in     = '0;
    bus.v_in     = '0;
    bus.w_in     = '0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_out_valid", int'(bus.out_valid), 0);
    check_output("reset_x_out", int'(bus.x_out), 0);
    check_output("reset_y_out", int'(bus.y_out), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    bus.mode = 1'b0; bus.u_in = 12'd100; bus.v_in = 12'd2; bus.w_in = 12'd100;
    #1;
    check_output("ct_mul_a", int'(bus.mul_a), 2);
    check_output("ct_mul_b", int'(bus.mul_b), 100);
    bus.mode = 1'b1; bus.u_in = 12'd5; bus.v_in = 12'd10; bus.w_in = 12'd2;
    #1;
    check_output("gs_mul_a", int'(bus.mul_a), 3324);
    check_output("gs_mul_b", int'(bus.mul_b), 2);

    apply_stimulus(1'b0, 1'b0, 100, 2, 100, 300, 3229, 1'b1);
    wait_drain();
    apply_stimulus(1'b0, 1'b0, 3000, 329, 1, 0, 2671, 1'b1);
    wait_drain();
    apply_stimulus(1'b1, 1'b0, 5, 10, 2, 15, 3319, 1'b1);
    wait_drain();
    apply_stimulus(1'b1, 1'b1, 5, 10, 2, 1672, 3324, 1'b1);
    wait_drain();

    // Eight back-to-back issues cycling through every mode/half_en pairing.
    for (int i = 0; i < 8; i++) begin
      gs   = i[0];
      half = i[1];
      u = (i == 0) ? Q - 1 : $urandom_range(0, Q - 1);
      v = (i == 0) ? Q - 1 : $urandom_range(0, Q - 1);
      w = (i == 1) ? Q - 1 : $urandom_range(0, Q - 1);
      e = golden(gs, half, u, v, w);
      apply_stimulus(gs, half, u, v, w, e.x, e.y, 1'b1);
    end
    wait_drain();

    check_output("idle_out_valid", int'(bus.out_valid), 0);
    check_output("idle_hold_x", int'(bus.x_out), last_x);
    check_output("idle_hold_y", int'(bus.y_out), last_y);

    apply_stimulus(1'b0, 1'b0, 11, 22, 33, 0, 0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 44, 55, 66, 0, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.u_in = 12'd77;
    rst = 1'b1;
    #1;
    check_output("midrst_out_valid", int'(bus.out_valid), 0);
    check_output("midrst_x_out", int'(bus.x_out), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) quiet++;
    end
    check_output("midrst_quiet", quiet, 0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b0, 7, 3, 5, 22, 3321, 1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got %0d cycles, expected completion", cycle);
    $fatal(1, "[TB] run did not complete");
  end

endmodule
